// File: rtl/mandel_pkg.sv
// Shared types and default frame geometry for the Mandelbrot pixel scheduler.
package mandel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } slot_state_t;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at the engine after the
// last one granted; the pointer only moves when the grant is actually used.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_grant,
    output logic         o_any
);

    localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU    = N;

    logic [IDX_W-1:0] r_last;
    int unsigned      w_best;
    int unsigned      w_best_d;
    int unsigned      w_d;

    // Distance from the last winner decides priority; smallest distance wins.
    always_comb begin
        w_best   = 0;
        w_best_d = NU;
        w_d      = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            w_d = (i > 32'(r_last)) ? (i - 32'(r_last) - 1) : (i + NU - 32'(r_last) - 1);
            if (i_req[i] && (w_d < w_best_d)) begin
                w_best_d = w_d;
                w_best   = i;
            end
        end
        o_any   = |i_req;
        o_grant = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (o_any && (w_best == i)) begin
                o_grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= IDX_W'(N - 1);
        end else if (i_adv && o_any) begin
            r_last <= IDX_W'(w_best);
        end
    end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Issues raster pixels to independent engines, reorders tagged results in a
// ROB and retires them in raster order on a valid/ready stream.
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 3,
    parameter int ITER_W      = 32,
    parameter int X_W         = 32,
    parameter int Y_W         = 32,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int ROB_DEPTH   = 16,
    parameter int TAG_W       = $clog2(ROB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          continuous,
    output logic                          busy,
    output logic                          frame_done,
    output logic [NUM_ENGINES-1:0]        eng_req_valid,
    input  logic [NUM_ENGINES-1:0]        eng_req_ready,
    output logic [NUM_ENGINES*X_W-1:0]    eng_x,
    output logic [NUM_ENGINES*Y_W-1:0]    eng_y,
    output logic [NUM_ENGINES*TAG_W-1:0]  eng_tag,
    input  logic [NUM_ENGINES-1:0]        eng_res_valid,
    input  logic [NUM_ENGINES*TAG_W-1:0]  eng_res_tag,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_res_iter,
    output logic [ITER_W-1:0]             iter_o,
    output logic                          valid,
    input  logic                          ready,
    output logic                          first,
    output logic                          last_x,
    output logic                          last_y,
    output logic                          err_tag
);

    localparam logic [X_W-1:0]   X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(HEIGHT - 1);
    localparam logic [TAG_W:0]   DEPTH  = (TAG_W + 1)'(ROB_DEPTH);

    fsm_state_t        r_state, w_next;
    logic [X_W-1:0]    r_ix, r_rx;
    logic [Y_W-1:0]    r_iy, r_ry;
    logic [TAG_W:0]    r_iseq, r_rseq, w_occ;
    slot_state_t       r_slot_st   [ROB_DEPTH];
    logic [ITER_W-1:0] r_slot_iter [ROB_DEPTH];
    logic [TAG_W-1:0]  w_res_tag   [NUM_ENGINES];
    logic [ITER_W-1:0] w_res_iter  [NUM_ENGINES];
    logic [TAG_W-1:0]  w_itag, w_rtag;
    logic [NUM_ENGINES-1:0] w_grant;
    logic              w_any, w_run, w_room, w_issue, w_hs, w_frame_end;
    logic              r_valid, r_first, r_last_x, r_last_y, r_frame_done, r_err;
    logic [ITER_W-1:0] r_iter;

    assign w_occ       = r_iseq - r_rseq;
    assign w_room      = w_occ < DEPTH;
    assign w_run       = (r_state == RUN);
    assign w_issue     = w_run && w_room && w_any;
    assign w_itag      = r_iseq[TAG_W-1:0];
    assign w_rtag      = r_rseq[TAG_W-1:0];
    assign w_hs        = r_valid && ready;
    assign w_frame_end = (r_state == DRAIN) && w_hs && r_last_y;

    rr_arbiter #(.N(NUM_ENGINES)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (eng_req_ready),
        .i_adv   (w_run && w_room),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_comb begin
        for (int unsigned e = 0; e < NUM_ENGINES; e++) begin
            w_res_tag[e]  = eng_res_tag[e*TAG_W +: TAG_W];
            w_res_iter[e] = eng_res_iter[e*ITER_W +: ITER_W];
        end
    end

    assign eng_req_valid = w_issue ? w_grant : '0;
    assign eng_x         = {NUM_ENGINES{r_ix}};
    assign eng_y         = {NUM_ENGINES{r_iy}};
    assign eng_tag       = {NUM_ENGINES{w_itag}};
    assign busy          = (r_state == RUN) || (r_state == DRAIN);
    assign frame_done    = r_frame_done;
    assign valid         = r_valid;
    assign iter_o        = r_iter;
    assign first         = r_first;
    assign last_x        = r_last_x;
    assign last_y        = r_last_y;
    assign err_tag       = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_issue && (r_ix == X_LAST) && (r_iy == Y_LAST)) w_next = DRAIN;
            DRAIN:   if (w_frame_end) w_next = continuous ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Issue counters wrap on the final pixel, so the next frame starts at (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ix   <= '0;
            r_iy   <= '0;
            r_iseq <= '0;
        end else if (w_issue) begin
            r_iseq <= r_iseq + 1'b1;
            if (r_ix == X_LAST) begin
                r_ix <= '0;
                r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + 1'b1;
            end else begin
                r_ix <= r_ix + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                r_slot_st[i]   <= EMPTY;
                r_slot_iter[i] <= '0;
            end
            r_rseq       <= '0;
            r_rx         <= '0;
            r_ry         <= '0;
            r_valid      <= 1'b0;
            r_iter       <= '0;
            r_first      <= 1'b0;
            r_last_x     <= 1'b0;
            r_last_y     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_hs) begin
                r_valid           <= 1'b0;
                r_iter            <= '0;
                r_first           <= 1'b0;
                r_last_x          <= 1'b0;
                r_last_y          <= 1'b0;
                r_slot_st[w_rtag] <= EMPTY;
                r_rseq            <= r_rseq + 1'b1;
                if (r_rx == X_LAST) begin
                    r_rx <= '0;
                    r_ry <= (r_ry == Y_LAST) ? '0 : r_ry + 1'b1;
                end else begin
                    r_rx <= r_rx + 1'b1;
                end
            end else if (!r_valid && (r_state != IDLE) && (r_slot_st[w_rtag] == DONE)) begin
                r_valid  <= 1'b1;
                r_iter   <= r_slot_iter[w_rtag];
                r_first  <= (r_rx == '0) && (r_ry == '0);
                r_last_x <= (r_rx == X_LAST);
                r_last_y <= (r_rx == X_LAST) && (r_ry == Y_LAST);
            end
            for (int unsigned e = 0; e < NUM_ENGINES; e++) begin
                if (eng_res_valid[e]) begin
                    if (r_slot_st[w_res_tag[e]] == PENDING) begin
                        r_slot_st[w_res_tag[e]]   <= DONE;
                        r_slot_iter[w_res_tag[e]] <= w_res_iter[e];
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
            if (w_issue) begin
                r_slot_st[w_itag] <= PENDING;
            end
        end
    end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench: behavioural engines with programmable latency feed the
// scheduler; a 4x2 frame is checked pixel by pixel against hand tables.
module tb_mandel_pixel_scheduler;

    localparam int N  = 3;
    localparam int TW = 2;
    localparam int IW = 16;
    localparam int XW = 8;
    localparam int YW = 8;

    logic clk = 1'b0;
    logic reset, start, continuous, ready;
    logic busy, frame_done, valid, first, last_x, last_y, err_tag;
    logic [N-1:0]    eng_req_valid, eng_req_ready;
    logic [N*XW-1:0] eng_x;
    logic [N*YW-1:0] eng_y;
    logic [N*TW-1:0] eng_tag;
    logic [N-1:0]    eng_res_valid = '0;
    logic [N*TW-1:0] eng_res_tag   = '0;
    logic [N*IW-1:0] eng_res_iter  = '0;
    logic [IW-1:0]   iter_o;

    logic [N-1:0]  m_busy = '0;
    int unsigned   m_cnt  [N];
    logic [TW-1:0] m_tag  [N];
    logic [IW-1:0] m_iter [N];
    int unsigned   lat    [N];
    logic          inj;
    logic [TW-1:0] inj_tag;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned maxo, stall_iss;
    logic [TW-1:0] first_res_tag;
    bit saw_dual;

    always #5 clk = ~clk;

    mandel_pixel_scheduler #(
        .NUM_ENGINES (N),
        .ITER_W      (IW),
        .X_W         (XW),
        .Y_W         (YW),
        .WIDTH       (4),
        .HEIGHT      (2),
        .ROB_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .continuous    (continuous),
        .busy          (busy),
        .frame_done    (frame_done),
        .eng_req_valid (eng_req_valid),
        .eng_req_ready (eng_req_ready),
        .eng_x         (eng_x),
        .eng_y         (eng_y),
        .eng_tag       (eng_tag),
        .eng_res_valid (eng_res_valid),
        .eng_res_tag   (eng_res_tag),
        .eng_res_iter  (eng_res_iter),
        .iter_o        (iter_o),
        .valid         (valid),
        .ready         (ready),
        .first         (first),
        .last_x        (last_x),
        .last_y        (last_y),
        .err_tag       (err_tag)
    );

    // Engines: result carries iter = 100 + 16*y + x after lat[e] cycles.
    assign eng_req_ready = ~m_busy;
    always @(posedge clk) begin
        for (int e = 0; e < N; e++) begin
            eng_res_valid[e] <= 1'b0;
            if (m_busy[e]) begin
                if (m_cnt[e] == 1) begin
                    eng_res_valid[e]          <= 1'b1;
                    eng_res_tag[e*TW +: TW]   <= m_tag[e];
                    eng_res_iter[e*IW +: IW]  <= m_iter[e];
                    m_busy[e]                 <= 1'b0;
                end else begin
                    m_cnt[e] <= m_cnt[e] - 1;
                end
            end else if (eng_req_valid[e]) begin
                m_busy[e] <= 1'b1;
                m_cnt[e]  <= lat[e];
                m_tag[e]  <= eng_tag[e*TW +: TW];
                m_iter[e] <= IW'(100 + 16 * eng_y[e*YW +: YW] + eng_x[e*XW +: XW]);
            end
        end
        if (inj) begin
            eng_res_valid[0]    <= 1'b1;
            eng_res_tag[TW-1:0] <= inj_tag;
            eng_res_iter[IW-1:0] <= 16'hDEAD;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},  32'(busy), 0);
        chk({pfx, "_valid"}, 32'(valid), 0);
        chk({pfx, "_req"},   32'(eng_req_valid), 0);
        chk({pfx, "_iter"},  32'(iter_o), 0);
        chk({pfx, "_fdone"}, 32'(frame_done), 0);
        chk({pfx, "_first"}, 32'(first), 0);
        chk({pfx, "_lx"},    32'(last_x), 0);
        chk({pfx, "_ly"},    32'(last_y), 0);
        chk({pfx, "_err"},   32'(err_tag), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic set_lat(input int unsigned a, input int unsigned b, input int unsigned c);
        lat[0] = a; lat[1] = b; lat[2] = c;
    endtask

    task automatic run_frame(input bit do_start, input int unsigned stall);
        int unsigned k, cyc, outst;
        bit got_first;
        int unsigned ex_iter [8];
        logic [7:0] exl, exy;
        ex_iter = '{100, 101, 102, 103, 116, 117, 118, 119};
        exl = 8'b1000_1000;
        exy = 8'b1000_0000;
        k = 0; cyc = 0; outst = 0; maxo = 0; stall_iss = 0;
        got_first = 1'b0; saw_dual = 1'b0;
        ready = (stall == 0);
        if (do_start) begin
            @(negedge clk); start = 1'b1;
        end
        while (k < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (stall != 0 && cyc == stall) ready = 1'b1;
            if (cyc == 1) chk("busy_run", 32'(busy), 1);
            if (|eng_req_valid) outst++;
            if (outst > maxo) maxo = outst;
            if (stall != 0 && cyc >= 10 && cyc < stall && |eng_req_valid) stall_iss++;
            if (stall != 0 && (cyc == 12 || cyc == stall - 1)) begin
                chk("hold_valid", 32'(valid), 1);
                chk("hold_iter",  32'(iter_o), 100);
                chk("hold_first", 32'(first), 1);
                chk("hold_lx",    32'(last_x), 0);
            end
            for (int e = 0; e < N; e++) begin
                if (!got_first && eng_res_valid[e]) begin
                    first_res_tag = eng_res_tag[e*TW +: TW];
                    got_first = 1'b1;
                end
            end
            if (eng_res_valid[1] && eng_res_valid[2] &&
                eng_res_tag[TW +: TW] == 2'd1 && eng_res_tag[2*TW +: TW] == 2'd2)
                saw_dual = 1'b1;
            if (valid && ready) begin
                chk("pix_iter",  32'(iter_o), ex_iter[k]);
                chk("pix_first", 32'(first), 32'(k == 0));
                chk("pix_lx",    32'(last_x), 32'(exl[k]));
                chk("pix_ly",    32'(last_y), 32'(exy[k]));
                k++;
                outst--;
            end
        end
        chk("frame_count", k, 8);
        @(negedge clk);
        chk("frame_done", 32'(frame_done), 1);
        chk("busy_end", 32'(busy), 32'(continuous));
        if (continuous) begin
            chk("cont_issue", 32'(|eng_req_valid), 1);
            for (int e = 0; e < N; e++) begin
                if (eng_req_valid[e]) begin
                    chk("cont_x", 32'(eng_x[e*XW +: XW]), 0);
                    chk("cont_y", 32'(eng_y[e*YW +: YW]), 0);
                end
            end
        end
        @(negedge clk);
        chk("fdone_pulse", 32'(frame_done), 0);
    endtask

    initial begin
        int unsigned w;
        reset = 1'b0; start = 1'b0; continuous = 1'b0; ready = 1'b1;
        inj = 1'b0; inj_tag = '0;
        set_lat(5, 5, 5);
        #1;
        chk_zero("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Fixed latency, free-flowing output.
        run_frame(1'b1, 0);
        chk("t1_err", 32'(err_tag), 0);

        // Mixed latencies: tag 1 (latency 2) comes back before tag 0.
        pulse_reset();
        set_lat(9, 2, 5);
        run_frame(1'b1, 0);
        chk("t2_first_res_tag", 32'(first_res_tag), 1);
        chk("t2_err", 32'(err_tag), 0);

        // Downstream stall: ROB fills to 4 and issue stops.
        set_lat(5, 5, 5);
        run_frame(1'b1, 20);
        chk("t3_max_outstanding", maxo, 4);
        chk("t3_issue_while_full", stall_iss, 0);

        // Tags 1 and 2 return in the same cycle.
        pulse_reset();
        set_lat(3, 6, 5);
        run_frame(1'b1, 0);
        chk("t4_dual", 32'(saw_dual), 1);
        chk("t4_err", 32'(err_tag), 0);

        // Spurious result into an EMPTY slot.
        set_lat(5, 5, 5);
        @(negedge clk); inj_tag = 2'd3; inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        @(negedge clk);
        chk("t5_err_set", 32'(err_tag), 1);
        continuous = 1'b1;
        run_frame(1'b1, 0);
        chk("t5_err_sticky", 32'(err_tag), 1);
        continuous = 1'b0;

        // Asynchronous reset in the middle of the back-to-back frame.
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("mid");
        @(negedge clk); reset = 1'b1;
        w = 0;
        while (!err_tag && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("stale_err", 32'(err_tag), 1);
        chk("stale_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
